mul16_seq_ctrl: RTL and testbench



---
 rtl/mul16_seq_pkg.sv | 19 +
 rtl/wallace_8bit.sv | 30 +++
 rtl/mul16_seq_ctrl.sv | 97 +++++++++
 tb/tb_mul16_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul16_seq_pkg.sv
// mul16_seq_pkg: shared types, sizes and helpers for the sequential 16x16 multiplier
package mul16_seq_pkg;
    localparam int OPW     = 16;
    localparam int RW      = 32;
    localparam int CHUNK   = 8;
    localparam int N_STEPS = 4;

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, FIX, DONE} mul_state_e;

    // Magnitude of a possibly signed operand; the most negative value maps onto itself as unsigned
    function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] x, input logic sgn);
        return (sgn && x[OPW-1]) ? ~x + 1'b1 : x;
    endfunction

    // Bitwise majority, the carry term of a 3:2 compressor row
    function automatic logic [2*CHUNK-1:0] maj3(input logic [2*CHUNK-1:0] x, y, z);
        return (x & y) | (x & z) | (y & z);
    endfunction
endpackage

// File: rtl/wallace_8bit.sv
// wallace_8bit: combinational 8x8 unsigned multiplier built from a 3:2 carry-save tree
module wallace_8bit
    import mul16_seq_pkg::*;
(
    input  logic [CHUNK-1:0]   i_a,
    input  logic [CHUNK-1:0]   i_b,
    output logic [2*CHUNK-1:0] o_p
);
    logic [2*CHUNK-1:0] w_pp [CHUNK];
    logic [2*CHUNK-1:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2, w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;

    for (genvar g = 0; g < CHUNK; g++) begin : g_pp
        assign w_pp[g] = i_b[g] ? ((2*CHUNK)'(i_a) << g) : '0;
    end

    // Eight rows reduce 8 -> 6 -> 4 -> 3 -> 2; carries dropped off the top are beyond the 16-bit product
    assign w_s0 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c0 = maj3(w_pp[0], w_pp[1], w_pp[2]) << 1;
    assign w_s1 = w_pp[3] ^ w_pp[4] ^ w_pp[5];
    assign w_c1 = maj3(w_pp[3], w_pp[4], w_pp[5]) << 1;
    assign w_s2 = w_s0 ^ w_c0 ^ w_s1;
    assign w_c2 = maj3(w_s0, w_c0, w_s1) << 1;
    assign w_s3 = w_c1 ^ w_pp[6] ^ w_pp[7];
    assign w_c3 = maj3(w_c1, w_pp[6], w_pp[7]) << 1;
    assign w_s4 = w_s2 ^ w_c2 ^ w_s3;
    assign w_c4 = maj3(w_s2, w_c2, w_s3) << 1;
    assign w_s5 = w_s4 ^ w_c4 ^ w_c3;
    assign w_c5 = maj3(w_s4, w_c4, w_c3) << 1;
    assign o_p  = w_s5 + w_c5;
endmodule

// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: four-cycle 16x16 signed/unsigned multiplier sharing one 8x8 array
module mul16_seq_ctrl
    import mul16_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_a,
    input  logic [OPW-1:0] in_b,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RW-1:0]  out_prod,
    output logic           busy
);
    mul_state_e       r_state;
    logic [OPW-1:0]   r_a_mag, r_b_mag;
    logic             r_neg;
    logic [RW-1:0]    r_acc;
    logic [1:0]       w_step, w_sh;
    logic [CHUNK-1:0] w_mul_a, w_mul_b;
    logic [OPW-1:0]   w_pp;
    logic [RW-1:0]    w_addend;

    // Byte-pair schedule is a function of the state alone: step s uses a byte s[0] and b byte s[1]
    always_comb begin
        w_step = r_state == MUL1 ? 2'd1 : r_state == MUL2 ? 2'd2 : r_state == MUL3 ? 2'd3 : 2'd0;
    end

    assign w_mul_a  = w_step[0] ? r_a_mag[OPW-1:CHUNK] : r_a_mag[CHUNK-1:0];
    assign w_mul_b  = w_step[1] ? r_b_mag[OPW-1:CHUNK] : r_b_mag[CHUNK-1:0];
    assign w_sh     = {1'b0, w_step[0]} + {1'b0, w_step[1]};
    assign w_addend = {{(RW-OPW){1'b0}}, w_pp} << {w_sh, 3'b000};

    wallace_8bit u_mul (
        .i_a(w_mul_a),
        .i_b(w_mul_b),
        .o_p(w_pp)
    );

    // Control FSM: accept, four accumulate steps, sign fix, then hold the result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a_mag   <= '0;
            r_b_mag   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            out_prod  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a_mag  <= mag(in_a, in_signed);
                    r_b_mag  <= mag(in_b, in_signed);
                    r_neg    <= in_signed & (in_a[OPW-1] ^ in_b[OPW-1]);
                    r_acc    <= '0;
                    r_state  <= MUL0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                MUL0: begin
                    r_acc   <= r_acc + w_addend;
                    r_state <= MUL1;
                end
                MUL1: begin
                    r_acc   <= r_acc + w_addend;
                    r_state <= MUL2;
                end
                MUL2: begin
                    r_acc   <= r_acc + w_addend;
                    r_state <= MUL3;
                end
                MUL3: begin
                    r_acc   <= r_acc + w_addend;
                    r_state <= FIX;
                end
                FIX: begin
                    r_acc     <= r_neg ? ~r_acc + 1'b1 : r_acc;
                    out_prod  <= r_neg ? ~r_acc + 1'b1 : r_acc;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb_mul16_seq_ctrl: randomized self-checking bench for mul16_seq_ctrl against an arithmetic model
module tb_mul16_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_prod;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    mul16_seq_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_signed(in_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prod(out_prod),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        return 32'(sa * sb);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, issues one operation, returns edges from accept to out_valid (-1 on timeout)
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [31:0] prod, output int lat);
        int n = 0;
        while (!in_ready && n < 30) begin step(); n++; end
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = -1;
        prod = 'x;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin lat = i; prod = out_prod; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_prod !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b out_prod=%h, need 1 0 0 00000000",
                     in_ready, busy, out_valid, out_prod);
        end
    endtask

    task automatic test_basic();
        logic [31:0] p;
        int lat;
        out_ready = 1'b1;
        run_op(16'h1234, 16'h5678, 1'b0, p, lat);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL basic_latency: got %0d edges, need 5", lat); end
        checks++;
        if (p !== 32'h06260060) begin failures++; $display("FAIL basic_prod: got %h, need 06260060", p); end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_done_flags: in_ready=%b busy=%b, need 0 1", in_ready, busy);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b busy=%b, need 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_corners();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [31:0] ve [6];
        logic [31:0] p;
        int lat;
        va = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000, 16'h0001};
        vb = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000};
        vs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ve = '{32'hFFFE0001, 32'h00000001, 32'h40000000, 32'hFFFF8000, 32'h00000000, 32'h00008000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], p, lat);
            checks++;
            if (lat !== 5 || p !== ve[i]) begin
                failures++;
                $display("FAIL corner_%0d: %h*%h s=%b got %h lat=%0d, need %h lat=5", i, va[i], vb[i], vs[i], p, lat, ve[i]);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b;
        logic [31:0] p, e;
        int lat;
        a = 16'($urandom); b = 16'($urandom);
        e = ref_mul(a, b, 1'b1);
        out_ready = 1'b0;
        run_op(a, b, 1'b1, p, lat);
        checks++;
        if (lat !== 5 || p !== e) begin
            failures++; $display("FAIL bp_result: got %h lat=%0d, need %h lat=5", p, lat, e);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            in_a = 16'($urandom); in_b = 16'($urandom); in_signed = 1'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_prod !== e || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: out_valid=%b out_prod=%h in_ready=%b, need 1 %h 0", i, out_valid, out_prod, in_ready, e);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] p;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        in_a = 16'h1234; in_b = 16'h4321; in_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_state: busy=%b out_valid=%b in_ready=%b, need 0 0 1", busy, out_valid, in_ready);
        end
        for (int i = 0; i < 10; i++) begin step(); if (out_valid) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midreset_no_output: saw out_valid %0d cycles, need 0", seen); end
        run_op(16'd3, 16'd5, 1'b0, p, lat);
        checks++;
        if (lat !== 5 || p !== 32'h0000000F) begin
            failures++; $display("FAIL midreset_after: got %h lat=%0d, need 0000000f lat=5", p, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [9];
        logic [15:0] qb [9];
        logic        qs [9];
        logic [31:0] e;
        int last = 0, acc_cyc, n;
        for (int i = 0; i < 9; i++) begin
            qa[i] = 16'($urandom); qb[i] = 16'($urandom); qs[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        in_a = qa[0]; in_b = qb[0]; in_signed = qs[0]; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!in_ready && n < 30) begin step(); n++; end
            step();
            acc_cyc = cyc;
            e = ref_mul(qa[i], qb[i], qs[i]);
            in_a = qa[i+1]; in_b = qb[i+1]; in_signed = qs[i+1];
            if (i > 0) begin
                checks++;
                if (acc_cyc - last != 7) begin
                    failures++; $display("FAIL b2b_interval_%0d: got %0d clocks, need 7", i, acc_cyc - last);
                end
            end
            last = acc_cyc;
            n = 0;
            while (!out_valid && n < 20) begin step(); n++; end
            checks++;
            if (out_valid !== 1'b1 || out_prod !== e) begin
                failures++;
                $display("FAIL b2b_prod_%0d: %h*%h s=%b got %h valid=%b, need %h", i, qa[i], qb[i], qs[i], out_prod, out_valid, e);
            end
        end
        in_valid = 1'b0;
        step(); step();
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
